// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared Data_Memory access types, DMCtrl codes and legality rule
package dm_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    typedef struct packed {
        logic        valid;
        port_id_t    port;
        logic        err;
        logic [31:0] data;
    } dm_resp_t;

    // Unsigned widths have no store form; unused DMCtrl codes are never legal.
    function automatic logic dm_legal(input logic [2:0] ctrl, input logic [1:0] addr_lo,
                                      input logic we);
        logic ok;
        case (ctrl)
            DM_B:    ok = 1'b1;
            DM_BU:   ok = !we;
            DM_H:    ok = !addr_lo[0];
            DM_HU:   ok = !we && !addr_lo[0];
            DM_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_align_check.sv
// rtl/dm_align_check.sv - width/alignment legality of the granted access
module dm_align_check
    import dm_pkg::*;
(
    input  logic [2:0] ctrl,
    input  logic [1:0] addr_lo,
    input  logic       we,
    output logic       legal
);

    assign legal = dm_legal(ctrl, addr_lo, we);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port Data_Memory arbiter with starvation guard and registered response
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [2:0]  p0_ctrl,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [2:0]  p1_ctrl,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic [31:0] dm_Address,
    output logic [31:0] dm_DataWr,
    output logic        dm_DMWr,
    output logic [2:0]  dm_DMCtrl,
    input  logic [31:0] dm_DataRd
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt;
    logic        at_limit;
    logic        g0;
    logic        g1;
    logic        accept;
    logic        legal;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_ctrl;
    logic        sel_we;
    dm_resp_t    resp;

    // Port 0 wins contention until port 1 has waited STARVE_MAX grants; reset blocks both.
    always_comb begin
        at_limit = (starve_cnt == STARVE_LIM);
        g0       = 1'b0;
        g1       = 1'b0;
        if (!rst) begin
            if (p0_req && p1_req) begin
                g0 = !at_limit;
                g1 = at_limit;
            end else begin
                g0 = p0_req;
                g1 = p1_req;
            end
        end
    end

    assign accept = g0 | g1;
    assign p0_gnt = g0;
    assign p1_gnt = g1;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_ctrl  = DM_B;
        sel_we    = 1'b0;
        if (g1) begin
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
            sel_ctrl  = p1_ctrl;
            sel_we    = p1_we;
        end else if (g0) begin
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
            sel_ctrl  = p0_ctrl;
            sel_we    = p0_we;
        end
    end

    dm_align_check u_align_check (
        .ctrl    (sel_ctrl),
        .addr_lo (sel_addr[1:0]),
        .we      (sel_we),
        .legal   (legal)
    );

    assign dm_Address = sel_addr;
    assign dm_DataWr  = sel_wdata;
    assign dm_DMCtrl  = sel_ctrl;
    assign dm_DMWr    = accept && sel_we && legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (g1 || !p1_req) begin
            starve_cnt <= '0;
        end else if (g0 && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Read data is captured from the combinational memory port in the granted cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp <= '0;
        end else begin
            resp.valid <= accept;
            resp.port  <= g1 ? PORT1 : PORT0;
            resp.err   <= accept && !legal;
            resp.data  <= (accept && !sel_we && legal) ? dm_DataRd : '0;
        end
    end

    assign p0_rvalid = resp.valid && (resp.port == PORT0);
    assign p1_rvalid = resp.valid && (resp.port == PORT1);
    assign p0_err    = p0_rvalid && resp.err;
    assign p1_err    = p1_rvalid && resp.err;
    assign p0_rdata  = p0_rvalid ? resp.data : '0;
    assign p1_rdata  = p1_rvalid ? resp.data : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with Data_Memory model
module tb_dm_arbiter;
    import dm_pkg::*;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [2:0]  p0_ctrl;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [2:0]  p1_ctrl;
    logic [31:0] dm_Address, dm_DataWr, dm_DataRd;
    logic        dm_DMWr;
    logic [2:0]  dm_DMCtrl;

    int checks = 0;
    int errors = 0;
    int ref_cnt = 0;
    bit [7:0] mem [64];
    bit [7:0] ref_mem [64];

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_ctrl(p0_ctrl),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_ctrl(p1_ctrl),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .dm_Address(dm_Address), .dm_DataWr(dm_DataWr), .dm_DMWr(dm_DMWr),
        .dm_DMCtrl(dm_DMCtrl), .dm_DataRd(dm_DataRd)
    );

    // Data_Memory: combinational read with extension, byte-lane write at the rising edge.
    always_comb begin : dm_read
        logic [31:0] word;
        word = {mem[6'(dm_Address[5:0] + 6'd3)], mem[6'(dm_Address[5:0] + 6'd2)],
                mem[6'(dm_Address[5:0] + 6'd1)], mem[dm_Address[5:0]]};
        case (dm_DMCtrl)
            3'b000:  dm_DataRd = {{24{word[7]}}, word[7:0]};
            3'b001:  dm_DataRd = {{16{word[15]}}, word[15:0]};
            3'b100:  dm_DataRd = {24'h0, word[7:0]};
            3'b101:  dm_DataRd = {16'h0, word[15:0]};
            default: dm_DataRd = word;
        endcase
    end

    always @(posedge clk) begin
        if (dm_DMWr) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0 || (k == 1 && dm_DMCtrl[1:0] != 2'b00) || dm_DMCtrl[1:0] == 2'b10)
                    mem[6'(dm_Address[5:0] + 6'(k))] <= dm_DataWr[8*k +: 8];
            end
        end
    end

    function automatic int ref_size(input bit [2:0] c);
        return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_legal(input bit [2:0] c, input bit [31:0] a, input bit we);
        if (!(c == 0 || c == 1 || c == 2 || c == 4 || c == 5)) return 1'b0;
        if (we && c[2]) return 1'b0;
        return (a % ref_size(c)) == 0;
    endfunction

    function automatic bit [31:0] ref_load(input bit [31:0] a, input bit [2:0] c);
        longint v = 0;
        int n = ref_size(c);
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 64]) << (8 * i);
        if (!c[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    task automatic ref_store(input bit [31:0] a, input bit [2:0] c, input bit [31:0] d);
        for (int i = 0; i < ref_size(c); i++) ref_mem[(a + i) % 64] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    task automatic set_p0(input bit r, input bit [31:0] a, input bit [31:0] d, input bit w, input bit [2:0] c);
        p0_req = r; p0_addr = a; p0_wdata = d; p0_we = w; p0_ctrl = c;
    endtask

    task automatic set_p1(input bit r, input bit [31:0] a, input bit [31:0] d, input bit w, input bit [2:0] c);
        p1_req = r; p1_addr = a; p1_wdata = d; p1_we = w; p1_ctrl = c;
    endtask

    task automatic idle();
        set_p0(0, 0, 0, 0, DM_B);
        set_p1(0, 0, 0, 0, DM_B);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_p0(1, 32'h0, 32'hFFFF_FFFF, 1, DM_W);
        set_p1(1, 32'h4, 32'hFFFF_FFFF, 1, DM_W);
        tick();
        checks++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL reset_p0_gnt: got %b want 0", p0_gnt); end
        checks++; if (p1_gnt !== 1'b0) begin errors++; $display("FAIL reset_p1_gnt: got %b want 0", p1_gnt); end
        checks++; if (dm_DMWr !== 1'b0) begin errors++; $display("FAIL reset_dmwr: got %b want 0", dm_DMWr); end
        checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", p0_rvalid, p1_rvalid); end
        checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h want 0", p0_rdata, p1_rdata); end
        checks++; if (p0_err !== 1'b0 || p1_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b want 00", p0_err, p1_err); end
        tick();
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_load_word();
        set_p1(1, 32'h08, 32'hDEAD_BEEF, 1, DM_W);
        #1;
        checks++; if (p1_gnt !== 1'b1 || dm_DMWr !== 1'b1) begin errors++; $display("FAIL preload_store: got gnt=%b wr=%b want 1 1", p1_gnt, dm_DMWr); end
        tick();
        set_p1(0, 0, 0, 0, DM_B);
        set_p0(1, 32'h08, 32'h0, 0, DM_W);
        #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt: got %b want 1", p0_gnt); end
        checks++; if (dm_DMWr !== 1'b0) begin errors++; $display("FAIL load_dmwr: got %b want 0", dm_DMWr); end
        tick();
        idle();
        checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("FAIL load_rvalid: got %b want 1", p0_rvalid); end
        checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", p0_rdata); end
        checks++; if (p0_err !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", p0_err); end
        checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL load_p1_rvalid: got %b want 0", p1_rvalid); end
        tick();
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL load_rvalid_one_cycle: got %b want 0", p0_rvalid); end
    endtask

    task automatic test_store_half();
        set_p1(1, 32'h0C, 32'hABCD_1234, 1, DM_H);
        #1;
        checks++; if (dm_DMWr !== 1'b1) begin errors++; $display("FAIL sh_dmwr: got %b want 1", dm_DMWr); end
        checks++; if (dm_DMCtrl !== 3'b001) begin errors++; $display("FAIL sh_dmctrl: got %b want 001", dm_DMCtrl); end
        checks++; if (dm_Address !== 32'h0C) begin errors++; $display("FAIL sh_addr: got %h want 0000000c", dm_Address); end
        tick();
        checks++; if (p1_rvalid !== 1'b1 || p1_err !== 1'b0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL sh_resp: got v=%b e=%b d=%h want 1 0 0", p1_rvalid, p1_err, p1_rdata); end
        set_p1(1, 32'h0C, 32'h0, 0, DM_HU);
        tick();
        idle();
        checks++; if (p1_rdata !== 32'h0000_1234) begin errors++; $display("FAIL lhu_rdata: got %h want 00001234", p1_rdata); end
        tick();
    endtask

    task automatic test_misaligned();
        set_p0(1, 32'h04, 32'hCAFE_F00D, 1, DM_W);
        tick();
        set_p0(1, 32'h06, 32'h1111_1111, 1, DM_W);
        #1;
        checks++; if (p0_gnt !== 1'b1 || dm_DMWr !== 1'b0) begin errors++; $display("FAIL mis_dmwr: got gnt=%b wr=%b want 1 0", p0_gnt, dm_DMWr); end
        tick();
        checks++; if (p0_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", p0_err); end
        checks++; if (p0_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h want 0", p0_rdata); end
        set_p0(1, 32'h04, 32'h0, 0, DM_W);
        tick();
        idle();
        checks++; if (p0_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_unchanged: got %h want cafef00d", p0_rdata); end
        tick();
    endtask

    task automatic test_illegal_ctrl();
        bit [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            set_p0(1, 32'h00, 32'h0, 0, bad[i]);
            tick();
            checks++; if (p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'h0) begin errors++; $display("FAIL illegal_ctrl_%b: got v=%b e=%b d=%h want 1 1 0", bad[i], p0_rvalid, p0_err, p0_rdata); end
        end
        idle();
        tick();
    endtask

    task automatic test_store_unsigned();
        set_p0(1, 32'h10, 32'h5566_7788, 1, DM_W);
        tick();
        set_p0(1, 32'h10, 32'h0000_00AA, 1, DM_BU);
        #1;
        checks++; if (dm_DMWr !== 1'b0) begin errors++; $display("FAIL sbu_dmwr: got %b want 0", dm_DMWr); end
        tick();
        checks++; if (p0_err !== 1'b1) begin errors++; $display("FAIL sbu_err: got %b want 1", p0_err); end
        set_p0(1, 32'h10, 32'h0000_BBBB, 1, DM_HU);
        #1;
        checks++; if (dm_DMWr !== 1'b0) begin errors++; $display("FAIL shu_dmwr: got %b want 0", dm_DMWr); end
        tick();
        set_p0(1, 32'h10, 32'h0, 0, DM_W);
        tick();
        idle();
        checks++; if (p0_rdata !== 32'h5566_7788) begin errors++; $display("FAIL sbu_unchanged: got %h want 55667788", p0_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        bit exp1;
        set_p0(1, 32'h20, 32'h0, 0, DM_W);
        set_p1(1, 32'h24, 32'h0, 0, DM_W);
        for (int i = 0; i < 10; i++) begin
            exp1 = (i % 5) == 4;
            #1;
            checks++; if (p0_gnt !== !exp1 || p1_gnt !== exp1) begin errors++; $display("FAIL starve_gnt[%0d]: got %b%b want %b%b", i, p0_gnt, p1_gnt, !exp1, exp1); end
            tick();
            checks++; if (p0_rvalid !== !exp1 || p1_rvalid !== exp1) begin errors++; $display("FAIL starve_rvalid[%0d]: got %b%b want %b%b", i, p0_rvalid, p1_rvalid, !exp1, exp1); end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_midstream();
        set_p0(1, 32'h20, 32'h0, 0, DM_W);
        set_p1(1, 32'h24, 32'h0, 0, DM_W);
        tick();
        tick();
        tick();
        rst = 1'b1;
        set_p0(1, 32'h20, 32'hFFFF_FFFF, 1, DM_W);
        #1;
        checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_discard: got v=%b d=%h want 0 0", p0_rvalid, p0_rdata); end
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_gnt: got %b%b want 00", p0_gnt, p1_gnt); end
        checks++; if (dm_DMWr !== 1'b0) begin errors++; $display("FAIL rstmid_dmwr: got %b want 0", dm_DMWr); end
        tick();
        checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid: got %b%b want 00", p0_rvalid, p1_rvalid); end
        rst = 1'b0;
        set_p0(1, 32'h20, 32'h0, 0, DM_W);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (p0_gnt !== (i != 4) || p1_gnt !== (i == 4)) begin errors++; $display("FAIL rstmid_restart[%0d]: got %b%b want %b%b", i, p0_gnt, p1_gnt, i != 4, i == 4); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        bit pend0 = 0, pend1 = 0, w0 = 0, w1 = 0, e0, e1, el, ewe;
        bit [31:0] a0 = 0, a1 = 0, d0 = 0, d1 = 0, ea, ed, erd;
        bit [2:0] c0 = 0, c1 = 0, ec;
        int r;
        for (int i = 0; i < 16; i++) begin
            d0 = $urandom;
            set_p0(1, 32'(i * 4), d0, 1, DM_W);
            ref_store(32'(i * 4), DM_W, d0);
            tick();
        end
        idle();
        tick();
        ref_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pend0 && $urandom_range(0, 9) < 6) begin
                pend0 = 1; a0 = $urandom_range(0, 63); d0 = $urandom; w0 = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 9); c0 = (r < 8) ? 3'(r) : DM_W;
            end
            if (!pend1 && $urandom_range(0, 9) < 6) begin
                pend1 = 1; a1 = $urandom_range(0, 63); d1 = $urandom; w1 = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 9); c1 = (r < 8) ? 3'(r) : DM_W;
            end
            set_p0(pend0, a0, d0, w0, c0);
            set_p1(pend1, a1, d1, w1, c1);
            e0 = pend0 && !(pend1 && ref_cnt == SMAX);
            e1 = pend1 && !e0;
            ea = e1 ? a1 : a0; ed = e1 ? d1 : d0; ewe = e1 ? w1 : w0; ec = e1 ? c1 : c0;
            el = ref_legal(ec, ea, ewe);
            erd = (!ewe && el) ? ref_load(ea, ec) : 32'h0;
            #1;
            checks++; if (p0_gnt !== e0 || p1_gnt !== e1) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b%b want %b%b", n, p0_gnt, p1_gnt, e0, e1); end
            checks++; if (dm_DMWr !== ((e0 || e1) && ewe && el)) begin errors++; $display("FAIL rnd_dmwr[%0d]: got %b want %b", n, dm_DMWr, (e0 || e1) && ewe && el); end
            if (e0 || e1) begin
                checks++; if (dm_Address !== ea || dm_DMCtrl !== ec || dm_DataWr !== ed) begin errors++; $display("FAIL rnd_mux[%0d]: got %h %b %h want %h %b %h", n, dm_Address, dm_DMCtrl, dm_DataWr, ea, ec, ed); end
            end else begin
                checks++; if (dm_Address !== 32'h0 || dm_DMCtrl !== 3'b000 || dm_DataWr !== 32'h0) begin errors++; $display("FAIL rnd_idle_mux[%0d]: got %h %b %h want 0", n, dm_Address, dm_DMCtrl, dm_DataWr); end
            end
            tick();
            checks++; if (p0_rvalid !== e0 || p1_rvalid !== e1) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", n, p0_rvalid, p1_rvalid, e0, e1); end
            if (e0) begin
                checks++; if (p0_err !== !el || p0_rdata !== erd) begin errors++; $display("FAIL rnd_p0_resp[%0d]: got e=%b d=%h want e=%b d=%h", n, p0_err, p0_rdata, !el, erd); end
            end
            if (e1) begin
                checks++; if (p1_err !== !el || p1_rdata !== erd) begin errors++; $display("FAIL rnd_p1_resp[%0d]: got e=%b d=%h want e=%b d=%h", n, p1_err, p1_rdata, !el, erd); end
            end
            if ((e0 || e1) && ewe && el) ref_store(ea, ec, ed);
            if (e1 || !pend1) ref_cnt = 0;
            else if (e0 && ref_cnt < SMAX) ref_cnt++;
            if (e0) pend0 = 0;
            if (e1) pend1 = 0;
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_word();
        test_store_half();
        test_misaligned();
        test_illegal_ctrl();
        test_store_unsigned();
        test_starvation();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
